// File: rtl/pipeline_sequencer_pkg.sv
// Shared types and constants for the pipeline front-end sequencer and the control unit.
package pipeline_sequencer_pkg;

  localparam int unsigned PC_W         = 10;
  localparam int unsigned DRAIN_CYCLES = 3;
  localparam int unsigned CNT_W        = 16;
  localparam int unsigned REG_W        = 4;
  localparam int unsigned OPC_W        = 5;

  localparam logic [REG_W-1:0] REG_ADR  = 4'd4;
  localparam logic [REG_W-1:0] REG_MATH = 4'd5;
  localparam logic [REG_W-1:0] REG_CNT  = 4'd7;

  localparam logic [OPC_W-1:0] OPC_HALT = 5'b11010;
  localparam logic [OPC_W-1:0] OPC_LD   = 5'b10110;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } seq_state_e;

  // Source operands of the instruction currently in ID.
  typedef struct packed {
    logic [REG_W-1:0] rs0;
    logic [REG_W-1:0] rs1;
    logic             use_rs0;
    logic             use_rs1;
  } id_regs_t;

  // Destination side of the instruction currently in EX.
  typedef struct packed {
    logic             mem_read;
    logic             reg_write;
    logic [REG_W-1:0] wr_reg;
  } ex_dst_t;

  // True when an operand is actually read and names the given destination.
  function automatic logic reads_reg(input logic used, input logic [REG_W-1:0] idx,
                                     input logic [REG_W-1:0] dst);
    return used && (idx == dst);
  endfunction

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Decode/execute side-band and fetch-control bundle between control unit and sequencer.
interface pipeline_sequencer_if #(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned CNT_W = 16
);
  logic             start_req;
  logic [PC_W-1:0]  start_pc;
  logic             id_halt;
  logic [3:0]       id_rs0;
  logic [3:0]       id_rs1;
  logic             id_use_rs0;
  logic             id_use_rs1;
  logic             ex_mem_read;
  logic             ex_reg_write;
  logic [3:0]       ex_wr_reg;
  logic             ex_branch_taken;
  logic [PC_W-1:0]  ex_branch_target;

  logic [PC_W-1:0]  pc;
  logic             imem_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             running;
  logic             halted;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output start_req, start_pc, id_halt, id_rs0, id_rs1, id_use_rs0, id_use_rs1,
           ex_mem_read, ex_reg_write, ex_wr_reg, ex_branch_taken, ex_branch_target,
    input  pc, imem_en, ifid_en, ifid_flush, idex_flush, running, halted,
           cycle_count, stall_count
  );

  modport slave (
    input  start_req, start_pc, id_halt, id_rs0, id_rs1, id_use_rs0, id_use_rs1,
           ex_mem_read, ex_reg_write, ex_wr_reg, ex_branch_taken, ex_branch_target,
    output pc, imem_en, ifid_en, ifid_flush, idex_flush, running, halted,
           cycle_count, stall_count
  );
endinterface

// File: rtl/pipeline_sequencer_load_use_detect.sv
// Combinational load-use hazard compare between the ID operands and the EX load destination.
module load_use_detect
  import pipeline_sequencer_pkg::*;
(
  input  id_regs_t id,
  input  ex_dst_t  ex,
  output logic     hazard_c
);

  // Full 4-bit compare so the special registers (adr, math, cnt) are covered too.
  always_comb begin
    hazard_c = 1'b0;
    if (ex.mem_read && ex.reg_write) begin
      hazard_c = reads_reg(id.use_rs0, id.rs0, ex.wr_reg) ||
                 reads_reg(id.use_rs1, id.rs1, ex.wr_reg);
    end
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Front-end controller: owns the PC, sequences fetch and drives IF/ID, ID/EX enables and flushes.
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int unsigned PC_W         = pipeline_sequencer_pkg::PC_W,
  parameter int unsigned DRAIN_CYCLES = pipeline_sequencer_pkg::DRAIN_CYCLES,
  parameter int unsigned CNT_W        = pipeline_sequencer_pkg::CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_sequencer_if.slave  bus
);

  localparam int unsigned DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYCLES - 1);

  seq_state_e       state;
  logic [PC_W-1:0]  pc_q;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] stall_q;
  logic [DRN_W-1:0] drain_q;
  logic             running_q;
  logic             halted_q;

  id_regs_t id_regs;
  ex_dst_t  ex_dst;
  logic     load_use_c;
  logic     in_run_c;
  logic     branch_c;
  logic     stall_c;
  logic     halt_c;

  assign id_regs = '{rs0: bus.id_rs0, rs1: bus.id_rs1,
                     use_rs0: bus.id_use_rs0, use_rs1: bus.id_use_rs1};
  assign ex_dst  = '{mem_read: bus.ex_mem_read, reg_write: bus.ex_reg_write,
                     wr_reg: bus.ex_wr_reg};

  load_use_detect u_load_use_detect (
    .id       (id_regs),
    .ex       (ex_dst),
    .hazard_c (load_use_c)
  );

  // Per-cycle RUN priority: taken branch, then load-use stall, then halt, else advance.
  always_comb begin
    in_run_c = (state == ST_RUN);
    branch_c = in_run_c && bus.ex_branch_taken;
    stall_c  = in_run_c && !bus.ex_branch_taken && load_use_c;
    halt_c   = in_run_c && !bus.ex_branch_taken && !load_use_c && bus.id_halt;
  end

  // Fetch/pipeline-register controls; outside RUN the front end is held full of bubbles.
  always_comb begin
    bus.imem_en    = 1'b0;
    bus.ifid_en    = 1'b0;
    bus.ifid_flush = 1'b1;
    bus.idex_flush = 1'b1;
    if (in_run_c) begin
      bus.imem_en    = 1'b1;
      bus.ifid_en    = !stall_c;
      bus.ifid_flush = branch_c || halt_c;
      bus.idex_flush = branch_c || stall_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      pc_q      <= '0;
      cycle_q   <= '0;
      stall_q   <= '0;
      drain_q   <= '0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HALTED: begin
          if (bus.start_req) begin
            state     <= ST_RUN;
            pc_q      <= bus.start_pc;
            cycle_q   <= '0;
            stall_q   <= '0;
            drain_q   <= '0;
            running_q <= 1'b1;
            halted_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (cycle_q != '1) cycle_q <= cycle_q + CNT_W'(1);
          if (branch_c) begin
            pc_q <= bus.ex_branch_target;
          end else if (stall_c) begin
            if (stall_q != '1) stall_q <= stall_q + CNT_W'(1);
          end else if (halt_c) begin
            state   <= ST_DRAIN;
            drain_q <= '0;
          end else begin
            pc_q <= pc_q + PC_W'(1);
          end
        end
        ST_DRAIN: begin
          if (cycle_q != '1) cycle_q <= cycle_q + CNT_W'(1);
          if (drain_q == DRN_LAST) begin
            state     <= ST_HALTED;
            drain_q   <= '0;
            running_q <= 1'b0;
            halted_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + DRN_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.pc          = pc_q;
  assign bus.running     = running_q;
  assign bus.halted      = halted_q;
  assign bus.cycle_count = cycle_q;
  assign bus.stall_count = stall_q;

endmodule
